// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage to 16-bit asynchronous SRAM bridge.
// A 32-bit load or store is split into two half-word phases (low half at the
// even SRAM address, high half at the odd one), each held for WAIT_CYCLES.
// `ready` low freezes the pipeline until the access reaches DONE.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; a request is accepted here
// LOW   | low half-word phase (even SRAM address, data[15:0])
// HIGH  | high half-word phase (odd SRAM address, data[31:16])
// DONE  | access complete for one cycle, ready high, then back to IDLE
module mem_stage_sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int IDX_W = SRAM_AW - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic          req;
  logic          phase_end;
  logic          accept;
  logic          low_end;
  logic          high_end;
  logic          op_wr;
  logic [15:0]   data_hi;
  logic [IDX_W-1:0] req_idx;

  assign req       = rd_en | wr_en;
  assign phase_end = (cnt == CNT_LAST);

  // Word index of the incoming request; wraps modulo 2^32, so addresses
  // below BASE_ADDR alias into the top of the SRAM rather than trapping.
  assign req_idx = IDX_W'((address - BASE_ADDR) >> 2);

  // State and phase counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic, phase events and the combinational SRAM strobes.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    accept     = 1'b0;
    low_end    = 1'b0;
    high_end   = 1'b0;

    case (state)
      S_IDLE: begin
        ready = !req;
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_LOW;
        end
      end

      S_LOW: begin
        sram_we_n  = !op_wr;
        sram_dq_oe = op_wr;
        if (phase_end) begin
          low_end   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_HIGH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_HIGH: begin
        sram_we_n  = !op_wr;
        sram_dq_oe = op_wr;
        if (phase_end) begin
          high_end  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      S_DONE: begin
        ready     = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Request latch, SRAM address/data registers and load-result capture.
  // sram_addr doubles as the latched address: the even half-word address is
  // loaded on accept and only its LSB flips when moving to the high phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr       <= 1'b0;
      data_hi     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      read_data   <= '0;
    end else begin
      if (accept) begin
        op_wr     <= wr_en;
        data_hi   <= write_data[31:16];
        sram_addr <= {req_idx, 1'b0};
        if (wr_en) begin
          sram_dq_out <= write_data[15:0];
        end
      end

      if (low_end) begin
        sram_addr[0] <= 1'b1;
        if (op_wr) begin
          sram_dq_out <= data_hi;
        end else begin
          read_data[15:0] <= sram_dq_in;
        end
      end

      if (high_end && !op_wr) begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: a W=2 instance against an SRAM array plus a
// 32-bit word reference memory, and a W=1 instance fed by a fixed SRAM pattern.
module tb_mem_stage_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd_en1, wr_en1;
  logic [31:0] address1, write_data1, read_data1;
  logic        ready1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_dq_out1, sram_dq_in1;
  logic        sram_dq_oe1, sram_we_n1;

  logic [15:0] sram [0:262143];
  logic        bd_en;
  logic [17:0] bd_addr;
  logic [15:0] bd_data;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
    .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
  );

  // Asynchronous SRAM model: combinational read, write on strobe, plus a backdoor.
  assign sram_dq_in = sram[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    else if (bd_en) sram[bd_addr] <= bd_data;
  end

  // Fixed read pattern for the W=1 instance.
  assign sram_dq_in1 = sram_addr1[15:0] ^ 16'h5A5A;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [17:0] half_addr(input logic [31:0] a);
    return 18'(((a - 32'd1024) >> 2) * 2);
  endfunction

  task automatic start(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
  endtask

  // Called at the negedge of cycle 0 with the request already driven.
  // Returns at the negedge of the DONE cycle, request still driven.
  task automatic finish(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit drop);
    int k; bit done; logic [17:0] ha;
    ha = half_addr(a);
    #1;
    check("req_ready", ready, 1'b0);
    k = 0; done = 0;
    while (!done && k < 40) begin
      @(negedge clk); k++;
      if (drop && k == 1) begin
        rd_en = 0; wr_en = 0; address = $urandom; write_data = $urandom;
      end
      #1;
      if (ready) done = 1;
      else if (k <= 2*W) begin
        check("sram_addr", sram_addr, (k <= W) ? ha : ha + 18'd1);
        check("we_n", sram_we_n, !wr);
        check("dq_oe", sram_dq_oe, wr);
        if (wr) check("dq_out", sram_dq_out, (k <= W) ? d[15:0] : d[31:16]);
      end
    end
    check("latency", k, 2*W+1);
    check("done_we_n", sram_we_n, 1'b1);
    if (wr) ref_mem[a] = d;
    else exp_rd = ref_rd(a);
    check("read_data", read_data, exp_rd);
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0;
    @(negedge clk); #1;
    check("idle_ready", ready, 1'b1);
    check("idle_we_n", sram_we_n, 1'b1);
  endtask

  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d, input bit drop);
    start(wr, rd, a, d);
    finish(wr, a, d, drop);
    idle();
  endtask

  task automatic w1_access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int k; bit done; int nwe; logic [17:0] ha; logic [15:0] lo, hi;
    ha = half_addr(a);
    rd_en1 = !wr; wr_en1 = wr; address1 = a; write_data1 = d;
    #1;
    check("w1_req_ready", ready1, 1'b0);
    k = 0; done = 0; nwe = 0;
    while (!done && k < 20) begin
      @(negedge clk); k++; #1;
      if (ready1) done = 1;
      else begin
        if (!sram_we_n1 && sram_dq_oe1) nwe++;
        if (wr && k == 2) check("w1_dq_out", sram_dq_out1, d[31:16]);
      end
    end
    check("w1_latency", k, 3);
    if (wr) check("w1_strobes", nwe, 2);
    else begin
      lo = ha[15:0] ^ 16'h5A5A;
      hi = (ha[15:0] + 16'd1) ^ 16'h5A5A;
      check("w1_read_data", read_data1, {hi, lo});
    end
    rd_en1 = 0; wr_en1 = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, d;
    bit chained, wr, drop;
    rst = 1; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en1 = 0; wr_en1 = 0; address1 = 0; write_data1 = 0;
    bd_en = 0; bd_addr = 0; bd_data = 0; exp_rd = 0;
    #2 rst = 0;

    // Reset values, with backdoor preload of SRAM[2]/[3] while held in reset.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_we_n", sram_we_n, 1'b1);
    check("rst_oe", sram_dq_oe, 1'b0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", sram_addr, 18'h0);
    check("rst_dq_out", sram_dq_out, 16'h0);
    bd_en = 1; bd_addr = 18'd2; bd_data = 16'h1111;
    @(negedge clk); bd_addr = 18'd3; bd_data = 16'h2222;
    @(negedge clk); bd_en = 0;
    ref_mem[32'd1028] = 32'h22221111;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_we_n", sram_we_n, 1'b1);
    check("post_rst_read_data", read_data, 32'h0);
    @(negedge clk);

    // Directed: store/load, mapping, simultaneous request, wrap-around.
    access(1, 0, 32'd1024, 32'hDEADBEEF, 0);
    check("sram0", sram[0], 16'hBEEF);
    check("sram1", sram[1], 16'hDEAD);
    access(0, 1, 32'd1024, 32'h0, 0);
    access(0, 1, 32'd1028, 32'h0, 0);
    access(1, 1, 32'd1032, 32'hCAFEF00D, 0);
    check("sram4", sram[4], 16'hF00D);
    check("sram5", sram[5], 16'hCAFE);
    access(1, 0, 32'd1020, 32'h01234567, 0);
    check("sram_wrap", sram[18'h3FFFE], 16'h4567);
    access(0, 1, 32'd1020, 32'h0, 0);

    // Drop rd_en during LOW: access still completes, ready pulses once.
    access(0, 1, 32'd1028, 32'h0, 1);
    @(negedge clk); #1;
    check("drop_idle_ready", ready, 1'b1);
    check("drop_no_restart", sram_addr[0], 1'b1);

    // Back-to-back: next request presented at the DONE edge.
    start(1, 0, 32'd1036, 32'h13579BDF);
    finish(1, 32'd1036, 32'h13579BDF, 0);
    start(0, 1, 32'd1036, 32'h0);
    @(negedge clk);
    finish(0, 32'd1036, 32'h0, 0);
    idle();

    // Reset during the HIGH phase of a store.
    access(1, 0, 32'd1040, 32'h11112222, 0);
    start(1, 0, 32'd1040, 32'hAAAABBBB);
    repeat (W+1) @(negedge clk);
    #1;
    check("pre_rst_we_n", sram_we_n, 1'b0);
    rst = 0;
    #1;
    check("mid_rst_we_n", sram_we_n, 1'b1);
    check("mid_rst_oe", sram_dq_oe, 1'b0);
    check("mid_rst_read_data", read_data, 32'h0);
    rd_en = 0; wr_en = 0;
    @(negedge clk); rst = 1;
    repeat (3) @(negedge clk);
    check("abort_hi_kept", sram[9], 16'h1111);
    check("abort_lo_written", sram[8], 16'hBBBB);
    exp_rd = 32'h0;
    ref_mem[32'd1040] = 32'h1111BBBB;
    access(0, 1, 32'd1040, 32'h0, 0);

    // Randomized mix of loads/stores, chaining and mid-access input drops.
    chained = 0;
    for (int i = 0; i < 40; i++) begin
      a = 32'd1024 + 32'd4 * $urandom_range(0, 15);
      d = $urandom;
      wr = ($urandom_range(0, 1) == 1) || !ref_mem.exists(a);
      drop = ($urandom_range(0, 3) == 0);
      start(wr, !wr, a, d);
      if (chained) @(negedge clk);
      finish(wr, a, d, drop);
      chained = ($urandom_range(0, 1) == 1) && !drop;
      if (!chained) idle();
    end
    if (chained) idle();

    // W=1 instance.
    w1_access(0, 32'd1028, 32'h0);
    w1_access(1, 32'd1024, 32'h89ABCDEF);
    for (int i = 0; i < 4; i++) w1_access(0, 32'd1024 + 32'd4 * $urandom_range(0, 255), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
